// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline datapath.
//   DATA_W, REG_AW : default datapath width and register address width
//   LS_BYTE/HALF/WORD : loadSize encodings (3 is reserved)
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

endpackage

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
// Bundles the MEM-stage inputs and the writeback outputs of mem_wb_stage.
//   master : drives the MEM-stage side (stall, flush, instruction fields)
//            and observes the writeback port and retire counter
//   slave  : the MEM/WB stage itself
//
// Flow control: there is no valid/ready handshake. inValid marks a real
// instruction on the MEM side, stall holds the MEM/WB register, flush loads
// a bubble (flush wins over stall). An instruction leaves WB, and is counted
// as retired, on every clock where the register holds a valid entry and
// stall is low.
// ---------------------------------------------------------------------------
interface mem_wb_stage_if
    import pipeline_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
);
    logic          stall;
    logic          flush;
    logic          inValid;
    logic          memToReg;
    logic          regWrite;
    logic [AW-1:0] rd;
    logic [DW-1:0] aluResult;
    logic [DW-1:0] memReadData;
    logic [1:0]    loadSize;
    logic          loadUnsigned;

    logic [DW-1:0] outMuxWb;
    logic          wbRegWrite;
    logic [AW-1:0] wbRd;
    logic          wbValid;
    logic          wbMisalign;
    logic [31:0]   retireCount;

    modport master (
        output stall, flush, inValid, memToReg, regWrite, rd,
               aluResult, memReadData, loadSize, loadUnsigned,
        input  outMuxWb, wbRegWrite, wbRd, wbValid, wbMisalign, retireCount
    );

    modport slave (
        input  stall, flush, inValid, memToReg, regWrite, rd,
               aluResult, memReadData, loadSize, loadUnsigned,
        output outMuxWb, wbRegWrite, wbRd, wbValid, wbMisalign, retireCount
    );
endinterface

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load alignment: picks the addressed byte/halfword out of the
// raw memory word and sign- or zero-extends it to DATA_W.
//   i_mem_read_data : raw word from data memory
//   i_offset        : byte offset within the word (address bits [1:0])
//   i_load_size     : LS_BYTE / LS_HALF / LS_WORD, 3 reserved
//   i_load_unsigned : 1 = zero-extend
//   o_data          : aligned, extended load value
//   o_misalign      : access is misaligned or uses the reserved size
//                     (not qualified by valid/memToReg; the stage does that)
// ---------------------------------------------------------------------------
module load_extend
    import pipeline_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic [DW-1:0] i_mem_read_data,
    input  logic [1:0]    i_offset,
    input  logic [1:0]    i_load_size,
    input  logic          i_load_unsigned,
    output logic [DW-1:0] o_data,
    output logic          o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    always_comb begin
        w_byte = i_mem_read_data[8*i_offset +: 8];
        // Only offsets 0 and 2 are legal for halfwords, so bit 1 selects.
        w_half = i_offset[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];
        w_sign = 1'b0;
        o_data = i_mem_read_data;
        case (i_load_size)
            LS_BYTE: begin
                w_sign = ~i_load_unsigned & w_byte[7];
                o_data = {{(DW-8){w_sign}}, w_byte};
            end
            LS_HALF: begin
                w_sign = ~i_load_unsigned & w_half[15];
                o_data = {{(DW-16){w_sign}}, w_half};
            end
            default: o_data = i_mem_read_data;
        endcase
    end

    assign o_misalign = ((i_load_size == LS_HALF) & i_offset[0])
                      | ((i_load_size == LS_WORD) & (i_offset != 2'd0))
                      | (i_load_size == 2'd3);

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register plus the writeback multiplexer.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mem_wb_stage_if.slave
//                in : stall, flush, inValid, memToReg, regWrite, rd,
//                     aluResult, memReadData, loadSize, loadUnsigned
//                out: outMuxWb, wbRegWrite, wbRd, wbValid, wbMisalign,
//                     retireCount
// Writeback outputs are combinational from the register (1-cycle latency).
// ---------------------------------------------------------------------------
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int REG_AW = pipeline_pkg::REG_AW
) (
    input  logic           clk,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);

    logic              r_valid;
    logic              r_mem_to_reg;
    logic              r_reg_write;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_mem_read_data;
    logic [1:0]        r_load_size;
    logic              r_load_unsigned;
    logic [31:0]       r_retire_count;

    logic [DATA_W-1:0] w_load_data;
    logic              w_load_misalign;
    logic              w_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid         <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_reg_write     <= 1'b0;
            r_rd            <= '0;
            r_alu_result    <= '0;
            r_mem_read_data <= '0;
            r_load_size     <= 2'd0;
            r_load_unsigned <= 1'b0;
            r_retire_count  <= 32'd0;
        end else begin
            // The occupant leaves WB whenever the stage is not stalled,
            // including when a flush replaces it with a bubble.
            if (r_valid && !bus.stall) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
            // Flush only kills the entry; the data fields keep their value.
            if (bus.flush) begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
            end else if (!bus.stall) begin
                r_valid         <= bus.inValid;
                r_mem_to_reg    <= bus.memToReg;
                r_reg_write     <= bus.regWrite;
                r_rd            <= bus.rd;
                r_alu_result    <= bus.aluResult;
                r_mem_read_data <= bus.memReadData;
                r_load_size     <= bus.loadSize;
                r_load_unsigned <= bus.loadUnsigned;
            end
        end
    end

    load_extend #(.DW(DATA_W)) u_load_extend (
        .i_mem_read_data (r_mem_read_data),
        .i_offset        (r_alu_result[1:0]),
        .i_load_size     (r_load_size),
        .i_load_unsigned (r_load_unsigned),
        .o_data          (w_load_data),
        .o_misalign      (w_load_misalign)
    );

    assign w_misalign = r_valid & r_mem_to_reg & w_load_misalign;

    assign bus.outMuxWb    = w_misalign   ? '0
                           : r_mem_to_reg ? w_load_data
                           :                r_alu_result;
    assign bus.wbRegWrite  = r_valid & r_reg_write & (r_rd != '0) & ~w_misalign;
    assign bus.wbRd        = r_rd;
    assign bus.wbValid     = r_valid;
    assign bus.wbMisalign  = w_misalign;
    assign bus.retireCount = r_retire_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed and randomized checking of mem_wb_stage against a behavioural
// model of the MEM/WB register, load alignment and retire counter.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        in_valid;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mrd;
        logic [1:0]  size;
        logic        uns;
    } stim_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.DW(32), .AW(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];

    // model of what currently sits in WB
    logic        m_valid = 1'b0;
    logic        m_m2r   = 1'b0;
    logic        m_rw    = 1'b0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_alu   = '0;
    logic [31:0] m_mrd   = '0;
    logic [1:0]  m_size  = '0;
    logic        m_uns   = 1'b0;
    logic [31:0] m_cnt   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected writeback computed from the load rules with plain arithmetic.
    function automatic void model_outputs(output logic [31:0] out,
                                          output logic reg_wr,
                                          output logic mis,
                                          output logic skip_out);
        int unsigned off;
        logic [31:0] v;
        logic        raw_mis;
        off     = m_alu % 4;
        raw_mis = (m_size == 2'd1 && (off % 2) == 1) ||
                  (m_size == 2'd2 && off != 0) || (m_size == 2'd3);
        mis     = m_valid && m_m2r && raw_mis;
        if (m_size == 2'd0) begin
            v = (m_mrd >> (8 * off)) % 256;
            if (!m_uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (m_size == 2'd1) begin
            v = (m_mrd >> (8 * off)) % 65536;
            if (!m_uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = m_mrd;
        end
        out      = mis ? 32'd0 : (m_m2r ? v : m_alu);
        reg_wr   = m_valid && m_rw && (m_rd != 0) && !mis;
        // Odd-offset halfword / reserved-size data is unspecified when the
        // entry is not valid (misalign is not flagged), so it is not checked.
        skip_out = !m_valid && m_m2r &&
                   ((m_size == 2'd1 && (off % 2) == 1) || m_size == 2'd3);
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input stim_t s);
        logic [31:0] e_out;
        logic        e_rw, e_mis, e_skip, got_skip;
        reset            = s.rst;
        bus.stall        = s.stall;
        bus.flush        = s.flush;
        bus.inValid      = s.in_valid;
        bus.memToReg     = s.mem_to_reg;
        bus.regWrite     = s.reg_write;
        bus.rd           = s.rd;
        bus.aluResult    = s.alu;
        bus.memReadData  = s.mrd;
        bus.loadSize     = s.size;
        bus.loadUnsigned = s.uns;
        @(posedge clk);
        if (s.rst) begin
            m_valid = 0; m_m2r = 0; m_rw = 0; m_rd = 0; m_alu = 0;
            m_mrd = 0; m_size = 0; m_uns = 0; m_cnt = 0;
        end else begin
            if (m_valid && !s.stall) m_cnt = m_cnt + 1;
            if (s.flush) begin
                m_valid = 0;
                m_rw    = 0;
            end else if (!s.stall) begin
                m_valid = s.in_valid; m_m2r = s.mem_to_reg; m_rw = s.reg_write;
                m_rd = s.rd; m_alu = s.alu; m_mrd = s.mrd;
                m_size = s.size; m_uns = s.uns;
            end
        end
        model_outputs(e_out, e_rw, e_mis, e_skip);
        exp_q.push_back(e_out);
        @(negedge clk);
        got_skip = e_skip;
        if (!got_skip) check_eq("outMuxWb", bus.outMuxWb, exp_q.pop_front());
        else void'(exp_q.pop_front());
        check_eq("wbRegWrite",  {31'd0, bus.wbRegWrite}, {31'd0, e_rw});
        check_eq("wbRd",        {27'd0, bus.wbRd},       {27'd0, m_rd});
        check_eq("wbValid",     {31'd0, bus.wbValid},    {31'd0, m_valid});
        check_eq("wbMisalign",  {31'd0, bus.wbMisalign}, {31'd0, e_mis});
        check_eq("retireCount", bus.retireCount,         m_cnt);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 0, stall: 0, flush: 0, in_valid: 0, mem_to_reg: 0,
              reg_write: 0, rd: 0, alu: 0, mrd: 0, size: 0, uns: 0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst        = ($urandom_range(0, 49) == 0);
        s.stall      = ($urandom_range(0, 3) == 0);
        s.flush      = ($urandom_range(0, 7) == 0);
        s.in_valid   = ($urandom_range(0, 3) != 0);
        s.mem_to_reg = $urandom_range(0, 1);
        s.reg_write  = ($urandom_range(0, 3) != 0);
        s.rd         = 5'($urandom_range(0, 31));
        s.alu        = $urandom;
        s.mrd        = $urandom;
        s.size       = 2'($urandom_range(0, 3));
        s.uns        = $urandom_range(0, 1);
        return s;
    endfunction

    function automatic stim_t load(input logic [31:0] alu, input logic [1:0] size,
                                   input logic uns);
        stim_t s;
        s = idle();
        s.in_valid = 1; s.mem_to_reg = 1; s.reg_write = 1; s.rd = 5'd7;
        s.alu = alu; s.mrd = 32'h80FF_7F01; s.size = size; s.uns = uns;
        return s;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        stim_t s;
        reset = 1'b1;

        // reset 2 cycles
        s = rand_stim(); s.rst = 1; cycle(s);
        s = rand_stim(); s.rst = 1; cycle(s);
        check_eq("rst_out", bus.outMuxWb, 32'd0);
        check_eq("rst_cnt", bus.retireCount, 32'd0);

        // ALU op
        s = idle(); s.in_valid = 1; s.reg_write = 1; s.rd = 5'd3; s.alu = 32'h2A;
        s.mrd = $urandom;
        cycle(s);
        check_eq("alu_out", bus.outMuxWb, 32'h2A);
        check_eq("alu_rd",  {27'd0, bus.wbRd}, 32'd3);
        check_eq("alu_we",  {31'd0, bus.wbRegWrite}, 32'd1);
        cycle(idle());
        check_eq("alu_cnt", bus.retireCount, 32'd1);

        // loads from 0x80FF7F01
        cycle(load(32'h1003, 2'd0, 1'b0));
        check_eq("ld_b_s", bus.outMuxWb, 32'hFFFF_FF80);
        cycle(load(32'h1003, 2'd0, 1'b1));
        check_eq("ld_b_u", bus.outMuxWb, 32'h0000_0080);
        cycle(load(32'h1002, 2'd1, 1'b0));
        check_eq("ld_h_s", bus.outMuxWb, 32'hFFFF_80FF);
        cycle(load(32'h1000, 2'd2, 1'b0));
        check_eq("ld_w", bus.outMuxWb, 32'h80FF_7F01);

        // misaligned halfword
        cycle(load(32'h1001, 2'd1, 1'b0));
        check_eq("mis_flag", {31'd0, bus.wbMisalign}, 32'd1);
        check_eq("mis_we",   {31'd0, bus.wbRegWrite}, 32'd0);
        check_eq("mis_out",  bus.outMuxWb, 32'd0);

        // rd = 0
        s = idle(); s.in_valid = 1; s.reg_write = 1; s.rd = 5'd0; s.alu = 32'h55;
        cycle(s);
        check_eq("rd0_we",    {31'd0, bus.wbRegWrite}, 32'd0);
        check_eq("rd0_valid", {31'd0, bus.wbValid}, 32'd1);

        // stall 3 cycles with new inputs
        s = idle(); s.in_valid = 1; s.reg_write = 1; s.rd = 5'd9; s.alu = 32'h1234;
        cycle(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 1;
            cycle(s);
            check_eq("stall_out", bus.outMuxWb, 32'h1234);
        end

        // flush together with stall
        s = rand_stim(); s.rst = 0; s.flush = 1; s.stall = 1;
        cycle(s);
        check_eq("flush_valid", {31'd0, bus.wbValid}, 32'd0);

        // inValid = 0 with regWrite = 1
        s = idle(); s.in_valid = 0; s.reg_write = 1; s.rd = 5'd4;
        cycle(s);
        check_eq("bubble_we", {31'd0, bus.wbRegWrite}, 32'd0);

        // reset during stall
        s = idle(); s.in_valid = 1; s.reg_write = 1; s.rd = 5'd5; s.alu = 32'hABCD;
        cycle(s);
        s = rand_stim(); s.rst = 1; s.stall = 1;
        cycle(s);
        check_eq("rst_stall_out",   bus.outMuxWb, 32'd0);
        check_eq("rst_stall_valid", {31'd0, bus.wbValid}, 32'd0);
        check_eq("rst_stall_cnt",   bus.retireCount, 32'd0);

        // counter wrap: preload the counter while the stage is stalled
        s = idle(); s.in_valid = 1; s.reg_write = 1; s.rd = 5'd6; s.alu = 32'h77;
        cycle(s);
        s = idle(); s.stall = 1;
        cycle(s);
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        m_cnt = 32'hFFFF_FFFF;
        cycle(idle());
        check_eq("wrap_cnt", bus.retireCount, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(rand_stim());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
